// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and direction constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic MEM_RW_READ  = 1'b1;
    localparam logic MEM_RW_WRITE = 1'b0;

endpackage

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational round-robin pick: first active request after the last winner
module rr_arb_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    int               w_sum;
    logic [IDX_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest active requester is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_sum  = 0;
        w_idx  = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_sum = (int'(last) + off) % NREQ;
            w_idx = IDX_W'(w_sum);
            if (req[w_idx]) begin
                winner = w_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner of the single memory port, one MFC-gated transaction per grant
// Optional ACCESS timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic                     mem_en,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mfc
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1) begin : g_bad_param
        $error("mem_port_arbiter: parameter out of range");
    end

    arb_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_last, w_last_nxt;
    logic [IDX_W-1:0]  r_win, w_win_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]   r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_rw, w_mem_rw_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;

    logic [IDX_W-1:0]  w_pick;
    logic              w_pick_valid;
    logic [NREQ-1:0]   w_pick_onehot;
    logic [NREQ-1:0]   w_win_onehot;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TMO_CYC + 1) > 4) ? $clog2(TMO_CYC + 1) : 4;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
`endif

    rr_arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_pick),
        .valid  (w_pick_valid)
    );

    assign w_pick_onehot = NREQ'(1) << w_pick;
    assign w_win_onehot  = NREQ'(1) << r_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= IDX_W'(NREQ - 1);
            r_win       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_win       <= w_win_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_rw    <= w_mem_rw_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_win_nxt       = r_win;
        w_gnt_nxt       = r_gnt;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_mem_en_nxt    = r_mem_en;
        w_mem_rw_nxt    = r_mem_rw;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_win_nxt       = w_pick;
                    w_gnt_nxt       = w_pick_onehot;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_rw_nxt    = req_rw[w_pick];
                    w_mem_addr_nxt  = req_addr[w_pick*ADDR_W +: ADDR_W];
                    w_mem_wdata_nxt = req_wdata[w_pick*DATA_W +: DATA_W];
                    w_state_nxt     = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_cnt_nxt       = '0;
`endif
                end
            end
            ACCESS: begin
                if (mfc) begin
                    if (r_mem_rw == MEM_RW_READ) begin
                        w_rdata_nxt = mem_rdata;
                    end
                    w_mem_en_nxt = 1'b0;
                    w_done_nxt   = w_win_onehot;
                    w_last_nxt   = r_win;
                    w_state_nxt  = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // Counter holds the number of ACCESS edges already spent without MFC.
                else if (r_cnt == CNT_W'(TMO_CYC - 1)) begin
                    w_mem_en_nxt = 1'b0;
                    w_done_nxt   = w_win_onehot;
                    w_err_nxt    = 1'b1;
                    w_last_nxt   = r_win;
                    w_state_nxt  = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                w_gnt_nxt   = '0;
                w_done_nxt  = '0;
                w_err_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

    localparam int NREQ    = 3;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TMO_CYC = 15;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   mem_en;
    logic                   mem_rw;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mfc;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_last;
    logic [15:0] m_rdata;

    mem_port_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mfc       (mfc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [2:0] rq, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (rq[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'(0));
        chk({tag, "_done"},  32'(done),      32'(0));
        chk({tag, "_err"},   32'(err),       32'(0));
        chk({tag, "_en"},    32'(mem_en),    32'(0));
        chk({tag, "_rw"},    32'(mem_rw),    32'(0));
        chk({tag, "_addr"},  32'(mem_addr),  32'(0));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(0));
        chk({tag, "_rdata"}, 32'(rdata),     32'(0));
    endtask

    // One complete grant: arbitration edge, delay ACCESS waits, MFC edge, RESP edge.
    task automatic do_txn(input logic [2:0] rq, input logic [2:0] rw, input logic [47:0] a,
                          input logic [47:0] d, input int delay, input bit drop_mid,
                          input logic [15:0] rd_val);
        int          w;
        logic [2:0]  oh;
        logic [15:0] ea, ed;
        logic        erw;
        w   = rr_pick(rq, m_last);
        oh  = 3'(1 << w);
        ea  = a[w*16 +: 16];
        ed  = d[w*16 +: 16];
        erw = rw[w];
        req = rq; req_rw = rw; req_addr = a; req_wdata = d; mfc = 1'b0;
        tick();
        chk("acc_gnt",   32'(gnt),       32'(oh));
        chk("acc_en",    32'(mem_en),    32'(1));
        chk("acc_rw",    32'(mem_rw),    32'(erw));
        chk("acc_addr",  32'(mem_addr),  32'(ea));
        chk("acc_wdata", 32'(mem_wdata), 32'(ed));
        chk("acc_done",  32'(done),      32'(0));
        for (int i = 0; i < delay; i++) begin
            req_addr  = rand48();
            req_wdata = rand48();
            req_rw    = 3'($urandom);
            if (drop_mid) req = req & ~oh;
            tick();
            chk("wait_en",    32'(mem_en),    32'(1));
            chk("wait_gnt",   32'(gnt),       32'(oh));
            chk("wait_addr",  32'(mem_addr),  32'(ea));
            chk("wait_wdata", 32'(mem_wdata), 32'(ed));
            chk("wait_rw",    32'(mem_rw),    32'(erw));
            chk("wait_done",  32'(done),      32'(0));
        end
        mfc = 1'b1;
        mem_rdata = rd_val;
        tick();
        if (erw) m_rdata = rd_val;
        m_last = w;
        chk("resp_done",  32'(done),   32'(oh));
        chk("resp_gnt",   32'(gnt),    32'(oh));
        chk("resp_en",    32'(mem_en), 32'(0));
        chk("resp_err",   32'(err),    32'(0));
        chk("resp_rdata", 32'(rdata),  32'(m_rdata));
        req = req & ~oh;
        mfc = 1'($urandom);
        tick();
        chk("idle_gnt",   32'(gnt),    32'(0));
        chk("idle_done",  32'(done),   32'(0));
        chk("idle_en",    32'(mem_en), 32'(0));
        chk("idle_err",   32'(err),    32'(0));
        chk("idle_rdata", 32'(rdata),  32'(m_rdata));
        mfc = 1'b0;
    endtask

    initial begin
        int          w;
        logic [2:0]  rq;
        logic [47:0] a;
        rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mfc = 1'b0;
        m_last = NREQ - 1; m_rdata = 16'h0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        req = 3'b001; req_rw = 3'b001; req_addr = 48'h0000_0000_00AA;
        tick();
        chk("rst_mid_en", 32'(mem_en), 32'(1));
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        tick();
        rst = 1'b0; req = '0;
        m_last = NREQ - 1; m_rdata = 16'h0;

        for (int i = 0; i < 4; i++) begin
            do_txn(3'b111, 3'($urandom), rand48(), rand48(), 0, 1'b0, 16'($urandom));
        end
        chk("contention_last", 32'(m_last), 32'(0));

        a = rand48();
        a[15:0] = 16'h0010;
        do_txn(3'b001, 3'b001, a, rand48(), 3, 1'b0, 16'hBEEF);
        chk("single_read_rdata", 32'(rdata), 32'hBEEF);

        a = rand48();
        a[31:16] = 16'h0004;
        do_txn(3'b010, 3'b000, a, 48'h0000_1234_0000, 2, 1'b0, 16'h5A5A);
        chk("write_keeps_rdata", 32'(rdata), 32'hBEEF);

        do_txn(3'b001, 3'b001, rand48(), rand48(), 2, 1'b1, 16'hC0DE);

        req = '0; mfc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_mfc_gnt", 32'(gnt),    32'(0));
            chk("idle_mfc_en",  32'(mem_en), 32'(0));
        end
        mfc = 1'b0;

        req = 3'b010; req_rw = 3'b010;
        w = rr_pick(3'b010, m_last);
        tick();
        chk("tmo_gnt", 32'(gnt), 32'(3'b010));
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < TMO_CYC; i++) begin
            tick();
            chk("tmo_wait_en", 32'(mem_en), 32'(1));
        end
        tick();
        chk("tmo_done",  32'(done),   32'(3'b010));
        chk("tmo_err",   32'(err),    32'(1));
        chk("tmo_en",    32'(mem_en), 32'(0));
        chk("tmo_rdata", 32'(rdata),  32'(m_rdata));
        m_last = w;
        req = '0;
        tick();
        chk("tmo_err_clr", 32'(err), 32'(0));
`else
        for (int i = 0; i < TMO_CYC + 5; i++) tick();
        chk("no_tmo_en",   32'(mem_en), 32'(1));
        chk("no_tmo_done", 32'(done),   32'(0));
        chk("no_tmo_err",  32'(err),    32'(0));
        mfc = 1'b1; mem_rdata = 16'h7777;
        tick();
        m_rdata = 16'h7777; m_last = w;
        chk("late_mfc_done", 32'(done), 32'(3'b010));
        req = '0; mfc = 1'b0;
        tick();
`endif

        for (int n = 0; n < 40; n++) begin
            rq = 3'($urandom_range(1, 7));
            do_txn(rq, 3'($urandom), rand48(), rand48(), $urandom_range(0, 4),
                   1'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                req = '0; mfc = 1'($urandom);
                tick();
                chk("rand_idle_gnt", 32'(gnt), 32'(0));
                mfc = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
